// File: rtl/uart_rx_oversampled_if.sv
// Receive-side handshake and status bundle between the UART receiver and its consumer.
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_ACK;
  logic                 FRAME_ERR;
  logic                 PARITY_ERR;
  logic                 OVERRUN;
  logic                 BUSY;

  modport master (
    output RX_DATA, RX_VALID, FRAME_ERR, PARITY_ERR, OVERRUN, BUSY,
    input  RX_ACK
  );

  modport slave (
    input  RX_DATA, RX_VALID, FRAME_ERR, PARITY_ERR, OVERRUN, BUSY,
    output RX_ACK
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop line synchroniser, majority-voted mid-bit sampling,
// optional parity, and a held word with valid/ack plus one-cycle error pulses.
module uart_rx_oversampled #(
  parameter int OVERSAMPLING_RATE = 8,
  parameter int DATA_BITS         = 8,
  parameter bit PARITY_EN         = 1'b0,
  parameter bit PARITY_ODD        = 1'b0
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic                  DIVPULSE,
  input  logic                  RXD,
  uart_rx_oversampled_if.master rx
);
  localparam int TW = $clog2(OVERSAMPLING_RATE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LO  = TW'(OVERSAMPLING_RATE / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLING_RATE / 2);
  localparam logic [TW-1:0] T_HI  = TW'(OVERSAMPLING_RATE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLING_RATE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_next;
  logic                 sync1, rxs;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [1:0]           vote;
  logic                 bit_val, par_bit, wait_high;
  logic                 maj, bit_store, shift_en, par_store, complete;
  logic                 parity_ok, word_ok;

  // Third vote is the live sample, so the decision lands on the last voting tick.
  assign maj       = (vote[0] & vote[1]) | (vote[0] & rxs) | (vote[1] & rxs);
  assign parity_ok = !PARITY_EN || ((^shreg ^ par_bit) == PARITY_ODD);
  assign word_ok   = complete && maj && parity_ok;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bit_store  = 1'b0;
    shift_en   = 1'b0;
    par_store  = 1'b0;
    complete   = 1'b0;
    rx.BUSY    = (state != IDLE);
    if (DIVPULSE) begin
      case (state)
        IDLE: if (!rxs && !wait_high) state_next = START;
        START: begin
          if (tcnt == T_HI && maj) state_next = IDLE;
          else if (tcnt == T_END)  state_next = DATA;
        end
        DATA: begin
          if (tcnt == T_HI) bit_store = 1'b1;
          if (tcnt == T_END) begin
            shift_en = 1'b1;
            if (bit_idx == BW'(DATA_BITS - 1)) state_next = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tcnt == T_HI)  par_store  = 1'b1;
          if (tcnt == T_END) state_next = STOP;
        end
        // Frame finishes at the stop-bit sample so a following start bit is not missed.
        STOP: begin
          if (tcnt == T_HI) begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      tcnt      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      vote      <= '0;
      bit_val   <= 1'b0;
      par_bit   <= 1'b0;
      wait_high <= 1'b0;
    end else begin
      sync1 <= RXD;
      rxs   <= sync1;
      if (DIVPULSE) begin
        if (state == IDLE || state_next == IDLE || tcnt == T_END) tcnt <= '0;
        else                                                      tcnt <= tcnt + TW'(1);
        if (tcnt == T_LO)  vote[0] <= rxs;
        if (tcnt == T_MID) vote[1] <= rxs;
      end
      if (state == IDLE) bit_idx <= '0;
      if (bit_store)     bit_val <= maj;
      if (par_store)     par_bit <= maj;
      if (shift_en) begin
        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      // A low stop bit may be a break; require an idle-high tick before rearming.
      if (complete && !maj)                        wait_high <= 1'b1;
      else if (DIVPULSE && state == IDLE && rxs)   wait_high <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rx.RX_DATA    <= '0;
      rx.RX_VALID   <= 1'b0;
      rx.FRAME_ERR  <= 1'b0;
      rx.PARITY_ERR <= 1'b0;
      rx.OVERRUN    <= 1'b0;
    end else begin
      rx.FRAME_ERR  <= complete && !maj;
      rx.PARITY_ERR <= complete && maj && !parity_ok;
      rx.OVERRUN    <= 1'b0;
      if (rx.RX_ACK) rx.RX_VALID <= 1'b0;
      // An ack in the completion cycle frees the buffer for the new word.
      if (word_ok) begin
        if (rx.RX_VALID && !rx.RX_ACK) begin
          rx.OVERRUN <= 1'b1;
        end else begin
          rx.RX_DATA  <= shreg;
          rx.RX_VALID <= 1'b1;
        end
      end
    end
  end
endmodule
